mult4x4_sequencer: RTL and testbench

Sequencing controller that computes an unsigned 4-bit × 4-bit product by time-multiplexing a single 2×2 partial-product multiplier (registered operands, combinational 2-bit adder, result readable one cycle after issue). It splits the operands into 2-bit digits, issues the four digit pairs in order, shift-accumulates the returned 4-bit partial products, and reports completion with a start/busy/done handshake. It sits between the user datapath and the 2×2 multiplier instance; the multiplier remains a separate, unmodified instance.

---
 rtl/mult4x4_sequencer.sv | 147 ++++++++++++++
 tb/tb_mult4x4_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mult4x4_sequencer.sv
// mult4x4_sequencer: computes an unsigned 4x4 product by issuing the four
// 2-bit digit pairs of the operands to an external 2x2 multiplier. That
// multiplier registers its operands, so each partial product comes back one
// cycle after issue and is shift-accumulated into an 8-bit accumulator.
module mult4x4_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] product,
  output logic       mA0,
  output logic       mA1,
  output logic       mB0,
  output logic       mB1,
  output logic       mIZero,
  input  logic       mS0,
  input  logic       mS1,
  input  logic       mS2,
  input  logic       mS3
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_next;
  logic [2:0]  idx, idx_next;
  logic [3:0]  op_a, op_a_next;
  logic [3:0]  op_b, op_b_next;
  logic [7:0]  acc, acc_next;
  logic [7:0]  product_reg, product_next;
  logic [1:0]  dig_a, dig_a_next;
  logic [1:0]  dig_b, dig_b_next;
  logic [3:0]  partial;
  logic [2:0]  weight;
  logic [7:0]  partial_shifted;
  logic [7:0]  acc_sum;

  assign partial         = {mS3, mS2, mS1, mS0};
  assign partial_shifted = 8'({4'b0000, partial}) << weight;
  assign acc_sum         = acc + partial_shifted;

  assign busy    = (state == RUN);
  assign done    = (state == DONE);
  assign product = product_reg;
  assign mA0     = dig_a[0];
  assign mA1     = dig_a[1];
  assign mB0     = dig_b[0];
  assign mB1     = dig_b[1];
  assign mIZero  = 1'b0;

  // Weight of the partial product arriving now, i.e. of the pair issued at idx-1.
  always_comb begin
    weight = 3'd0;
    case (idx)
      3'd1:    weight = 3'd0;
      3'd2:    weight = 3'd2;
      3'd3:    weight = 3'd2;
      3'd4:    weight = 3'd4;
      default: weight = 3'd0;
    endcase
  end

  // Registers for state, step counter, operands, accumulator and digit outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= 3'd0;
      op_a        <= 4'd0;
      op_b        <= 4'd0;
      acc         <= 8'd0;
      product_reg <= 8'd0;
      dig_a       <= 2'd0;
      dig_b       <= 2'd0;
    end else begin
      state       <= state_next;
      idx         <= idx_next;
      op_a        <= op_a_next;
      op_b        <= op_b_next;
      acc         <= acc_next;
      product_reg <= product_next;
      dig_a       <= dig_a_next;
      dig_b       <= dig_b_next;
    end
  end

  // Next-state logic: accept in IDLE/DONE, walk the four digit pairs in RUN.
  always_comb begin
    state_next   = state;
    idx_next     = idx;
    op_a_next    = op_a;
    op_b_next    = op_b;
    acc_next     = acc;
    product_next = product_reg;
    dig_a_next   = 2'd0;
    dig_b_next   = 2'd0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = RUN;
          idx_next   = 3'd0;
          op_a_next  = a;
          op_b_next  = b;
          acc_next   = 8'd0;
          dig_a_next = a[1:0];
          dig_b_next = b[1:0];
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (idx != 3'd0) begin
          acc_next = acc_sum;
        end
        if (idx == 3'd4) begin
          state_next   = DONE;
          product_next = acc_sum;
        end else begin
          idx_next = idx + 3'd1;
        end
        case (idx)
          3'd0: begin
            dig_a_next = op_a[3:2];
            dig_b_next = op_b[1:0];
          end
          3'd1: begin
            dig_a_next = op_a[1:0];
            dig_b_next = op_b[3:2];
          end
          3'd2: begin
            dig_a_next = op_a[3:2];
            dig_b_next = op_b[3:2];
          end
          default: begin
            dig_a_next = 2'd0;
            dig_b_next = 2'd0;
          end
        endcase
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mult4x4_sequencer.sv
// tb_mult4x4_sequencer: drives the sequencer together with a behavioural
// 2x2 multiplier and compares every cycle against expectations derived
// from plain arithmetic on the operands.
module tb_mult4x4_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] a = 4'd0;
  logic [3:0] b = 4'd0;
  logic       busy, done;
  logic [7:0] product;
  logic       mA0, mA1, mB0, mB1, mIZero;
  logic       mS0, mS1, mS2, mS3;

  logic [1:0] mul_a = 2'd0;
  logic [1:0] mul_b = 2'd0;
  logic [3:0] mul_out;

  int checks = 0;
  int errors = 0;
  int last_product = 0;

  mult4x4_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product),
    .mA0(mA0), .mA1(mA1), .mB0(mB0), .mB1(mB1), .mIZero(mIZero),
    .mS0(mS0), .mS1(mS1), .mS2(mS2), .mS3(mS3)
  );

  always #5 clk = ~clk;

  // Behavioural 2x2 multiplier: registered operands, combinational product.
  always @(posedge clk) begin
    mul_a <= {mA1, mA0};
    mul_b <= {mB1, mB0};
  end
  assign mul_out = mul_a * mul_b;
  assign {mS3, mS2, mS1, mS0} = mul_out;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Quiet cycles: nothing running, product must hold the last result.
  task automatic checkIdle(input string tag);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_done"}, int'(done), 0);
    checkOutput({tag, "_product"}, int'(product), last_product);
    checkOutput({tag, "_digits"}, int'({mA1, mA0, mB1, mB0}), 0);
    checkOutput({tag, "_izero"}, int'(mIZero), 0);
  endtask

  // One multiplication: optional idle gap, start pulse in cycle 0, then
  // cycles 1..6 checked; intr (1..5) pulses an ignored start mid-run.
  task automatic applyStimulus(input int x, input int y, input int gap, input int intr);
    int k, exp_a, exp_b;
    for (int g = 0; g < gap; g++) begin
      start = 1'b0;
      tick();
      checkIdle("gap");
    end
    start = 1'b1;
    a = 4'(x);
    b = 4'(y);
    for (int c = 1; c <= 6; c++) begin
      tick();
      start = 1'b0;
      if (c <= 4) begin
        k = c - 1;
        exp_a = (x >> (2 * (k % 2))) & 3;
        exp_b = (y >> (2 * (k / 2))) & 3;
      end else begin
        exp_a = 0;
        exp_b = 0;
      end
      checkOutput("busy", int'(busy), (c <= 5) ? 1 : 0);
      checkOutput("done", int'(done), (c == 6) ? 1 : 0);
      checkOutput("digitA", int'({mA1, mA0}), exp_a);
      checkOutput("digitB", int'({mB1, mB0}), exp_b);
      checkOutput("izero", int'(mIZero), 0);
      checkOutput("product", int'(product), (c == 6) ? x * y : last_product);
      if (c == intr) begin
        start = 1'b1;
        a = 4'($urandom_range(0, 15));
        b = 4'($urandom_range(0, 15));
      end
    end
    last_product = x * y;
  endtask

  // Start a multiplication and hit reset in the given cycle; no done may follow.
  task automatic resetDuringRun(input int x, input int y, input int rst_cycle);
    start = 1'b1;
    a = 4'(x);
    b = 4'(y);
    for (int c = 1; c <= rst_cycle; c++) begin
      tick();
      start = 1'b0;
      checkOutput("preRstBusy", int'(busy), 1);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last_product = 0;
    checkIdle("postRst");
    for (int c = 0; c < 6; c++) begin
      tick();
      checkIdle("afterRst");
    end
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    checkIdle("reset");
    rst = 1'b0;
    tick();
    checkIdle("resetRelease");

    applyStimulus(15, 15, 2, 0);
    applyStimulus(6, 9, 1, 0);
    applyStimulus(0, 13, 1, 0);
    applyStimulus(13, 1, 0, 0);
    applyStimulus(7, 11, 1, 3);
    resetDuringRun(9, 9, 3);
    applyStimulus(3, 5, 1, 0);
    applyStimulus(5, 5, 2, 0);
    applyStimulus(12, 10, 0, 0);

    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        applyStimulus(i, j, int'($urandom_range(0, 1)), int'($urandom_range(0, 5)));
      end
    end

    for (int n = 0; n < 40; n++) begin
      applyStimulus(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 5)));
    end

    start = 1'b0;
    tick();
    checkIdle("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
